// File: rtl/clk_div_prog.sv
// Programmable multi-channel clock divider: each channel produces a one-cycle tick
// every div cycles and a square (mode 0) or pulse (mode 1) clk_out, reconfigurable on the fly.
module clk_div_prog #(
  parameter  int N_CH    = 2,
  parameter  int CNT_W   = 26,
  parameter  int DEF_DIV = 33554432,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_mode,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  clk_out
);

  logic [N_CH-1:0] sel;
  logic [N_CH-1:0] pend;
  logic            accept;

  // An out-of-range cfg_ch selects no channel, so it is always ready and changes nothing.
  assign cfg_ready = rst || ((sel & pend) == '0);
  assign accept    = cfg_valid && cfg_ready && !rst;

  for (genvar gi = 0; gi < N_CH; gi++) begin : ch_g
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] div_reg, div_next;
    logic [CNT_W-1:0] sh_div_reg, sh_div_next;
    logic             mode_reg, mode_next;
    logic             sh_mode_reg, sh_mode_next;
    logic             pend_reg, pend_next;
    logic             tick_reg, tick_next;
    logic             clk_out_reg, clk_out_next;
    logic             active;
    logic             wrap;
    logic             take;

    assign sel[gi]     = (cfg_ch == CH_W'(gi));
    assign active      = en[gi] && (div_reg != '0);
    assign wrap        = active && (cnt_reg == div_reg - CNT_W'(1));
    assign take        = accept && sel[gi];
    assign pend[gi]    = pend_reg;
    assign tick[gi]    = tick_reg;
    assign clk_out[gi] = clk_out_reg;

    always_comb begin
      cnt_next     = cnt_reg;
      div_next     = div_reg;
      mode_next    = mode_reg;
      sh_div_next  = sh_div_reg;
      sh_mode_next = sh_mode_reg;
      pend_next    = pend_reg;
      tick_next    = 1'b0;
      clk_out_next = clk_out_reg;

      // Accept only happens with pend_reg clear, so it never collides with an apply below.
      if (take) begin
        sh_div_next  = cfg_div;
        sh_mode_next = cfg_mode;
        pend_next    = 1'b1;
      end

      if (!active) begin
        // An idle (div=0) channel never wraps, so a pending update is applied at once
        // just like on a disabled channel; otherwise it could never leave div=0.
        if (pend_reg) begin
          div_next     = sh_div_reg;
          mode_next    = sh_mode_reg;
          pend_next    = 1'b0;
          cnt_next     = '0;
          clk_out_next = 1'b0;
        end else if (div_reg == '0) begin
          cnt_next     = '0;
          clk_out_next = 1'b0;
        end
      end else if (wrap) begin
        cnt_next  = '0;
        tick_next = 1'b1;
        if (pend_reg && (sh_mode_reg != mode_reg)) begin
          clk_out_next = 1'b0;
        end else begin
          clk_out_next = mode_reg ? 1'b1 : ~clk_out_reg;
        end
        if (pend_reg) begin
          div_next  = sh_div_reg;
          mode_next = sh_mode_reg;
          pend_next = 1'b0;
        end
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (mode_reg) begin
          clk_out_next = 1'b0;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg     <= '0;
        div_reg     <= CNT_W'(DEF_DIV);
        mode_reg    <= 1'b0;
        sh_div_reg  <= CNT_W'(DEF_DIV);
        sh_mode_reg <= 1'b0;
        pend_reg    <= 1'b0;
        tick_reg    <= 1'b0;
        clk_out_reg <= 1'b0;
      end else begin
        cnt_reg     <= cnt_next;
        div_reg     <= div_next;
        mode_reg    <= mode_next;
        sh_div_reg  <= sh_div_next;
        sh_mode_reg <= sh_mode_next;
        pend_reg    <= pend_next;
        tick_reg    <= tick_next;
        clk_out_reg <= clk_out_next;
      end
    end
  end

endmodule
